// File: rtl/stavka_c.sv
// stavka_c: normalizes a 6-bit mantissa / 4-bit exponent pair down to a
// 3-bit mantissa, saturating the exponent at 15.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (m_in, e_in)
//   out_valid/out_ready result handshake (m_out, e_out, ovf)
//
// Build option: define STAVKA_C_ROUND_EN to round half up on the
// last shifted-out bit; otherwise results truncate toward zero.
module stavka_c (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] m_in,
    input  logic [3:0] e_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] m_out,
    output logic [3:0] e_out,
    output logic       ovf
);

`ifdef STAVKA_C_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] m_q, m_d;
    logic [3:0] e_q, e_d;
    logic       g_q, g_d;
    logic       ovf_q, ovf_d;

    // Rounded mantissa, one bit wider so a carry out to 8 is visible.
    logic [3:0] m_rnd;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        g_d     = g_q;
        ovf_d   = ovf_q;
        m_rnd   = {1'b0, m_q[2:0]} + {3'b000, g_q};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    g_d   = 1'b0;
                    ovf_d = 1'b0;
                    if (m_in == 6'd0) begin
                        // Zero has no exponent to keep.
                        m_d     = 6'd0;
                        e_d     = 4'd0;
                        state_d = DONE;
                    end else begin
                        m_d     = m_in;
                        e_d     = e_in;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (m_q >= 6'd8) begin
                    if (e_q != 4'd15) begin
                        m_d = {1'b0, m_q[5:1]};
                        g_d = m_q[0];
                        e_d = e_q + 4'd1;
                    end else begin
                        m_d     = 6'd7;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    if (ROUND_EN && g_q) begin
                        if (m_rnd[3]) begin
                            // Carry out: renormalize by one more step.
                            if (e_q != 4'd15) begin
                                m_d = 6'd4;
                                e_d = e_q + 4'd1;
                            end else begin
                                m_d   = 6'd7;
                                ovf_d = 1'b1;
                            end
                        end else begin
                            m_d = {2'b00, m_rnd};
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= 6'd0;
            e_q     <= 4'd0;
            g_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            g_q     <= g_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign m_out     = m_q[2:0];
    assign e_out     = e_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stavka_c.sv
// tb_stavka_c: scoreboard bench for stavka_c with directed and random
// operands checked against an arithmetic reference model.
module tb_stavka_c;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] m_in = 6'd0;
    logic [3:0] e_in = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] m_out;
    logic [3:0] e_out;
    logic       ovf;

    stavka_c dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .m_in     (m_in),
        .e_in     (e_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .m_out    (m_out),
        .e_out    (e_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int e;
        int ov;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    int   stall_left = 0;
    bit   seen = 0;
    bit   prev_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Value model: m*2^e reduced to a 3-bit mantissa.
    function automatic exp_t model(input int m, input int e);
        exp_t r;
        int   bl;
        int   k;
        r.acc = 0;
        if (m == 0) begin
            r.m = 0; r.e = 0; r.ov = 0; r.lat = 0;
            return r;
        end
        bl = 0;
        while ((m >> bl) != 0) bl++;
        k = (bl > 3) ? bl - 3 : 0;
        if (e + k > 15) begin
            r.m = 7; r.e = 15; r.ov = 1; r.lat = (15 - e) + 1;
            return r;
        end
        r.m = m >> k;
        r.e = e + k;
        r.ov = 0;
        r.lat = k + 1;
`ifdef STAVKA_C_ROUND_EN
        if (k > 0 && ((m >> (k - 1)) & 1) == 1) begin
            r.m = r.m + 1;
            if (r.m == 8) begin
                if (r.e < 15) begin
                    r.m = 4; r.e = r.e + 1;
                end else begin
                    r.m = 7; r.ov = 1;
                end
            end
        end
`endif
        return r;
    endfunction

    task automatic send(input int m, input int e);
        exp_t x;
        int   w;
        @(negedge clk);
        in_valid = 1'b1;
        m_in = 6'(m);
        e_in = 4'(e);
        w = 0;
        while (!in_ready) begin
            if (w >= 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            w++;
        end
        x = model(m, e);
        x.acc = cyc + 1;
        sb.push_back(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Monitor: drives out_ready and checks every cycle the result is shown.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    if (out_valid) stall_left--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (prev_hs) chk("ready_after_done", int'(in_ready), 1);
                prev_hs = 0;
                if (sb.size() > 0 && sb[0].acc <= cyc)
                    chk("busy_in_ready", int'(in_ready), 0);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_valid", 1, 0);
                    end else begin
                        chk("m_out", int'(m_out), sb[0].m);
                        chk("e_out", int'(e_out), sb[0].e);
                        chk("ovf", int'(ovf), sb[0].ov);
                        if (!seen) chk("latency", cyc - sb[0].acc, sb[0].lat);
                        seen = 1;
                        if (out_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
                            prev_hs = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_m_out", int'(m_out), 0);
        chk("rst_e_out", int'(e_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        send(5, 3);
        drain();
        send(48, 2);
        drain();
        send(15, 0);
        drain();
        send(40, 14);
        drain();
        send(7, 15);
        drain();
        send(63, 15);
        drain();
        stall_left = 5;
        send(0, 9);
        drain();
        stall_left = 0;

        for (int i = 0; i < 150; i++) begin
            send(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
        end
        drain();

        // Reset while the 63 operand is still being normalized.
        @(negedge clk);
        in_valid = 1'b1;
        m_in = 6'd63;
        e_in = 4'd0;
        chk("pre_abort_ready", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_m_out", int'(m_out), 0);
        chk("abort_e_out", int'(e_out), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);

        send(9, 4);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
